// File: rtl/scrambler_pkg.sv
// Shared definitions for the scrambler serial-in polynomial mux sequencer.
//   SEL_W   : width of the mux phase select
//   NUM_SEL : number of mux phases (select wraps NUM_SEL-1 -> 0)
//   DATA_W  : mux word width
//   LEN_W   : width of the frame length in words
//   seq_state_t : sequencer FSM states
package scrambler_pkg;
  localparam int SEL_W   = 5;
  localparam int NUM_SEL = 32;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;
endpackage

// File: rtl/scrambler_seq_outreg.sv
// Single-entry valid/ready output register for the mux sequencer.
// Holds one mux word plus its last-word marker until downstream accepts it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop the held word (valid/last cleared), data untouched
//   load       : capture load_data/load_last and raise valid
//   load_data  : word to capture
//   load_last  : last-word marker to capture
//   ready      : downstream accepts the held word
//   data       : held word
//   valid      : held word is valid
//   last       : held word is the final word of the frame
module scrambler_seq_outreg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              last_p1;

  // Stage p1: output register; a load in the same cycle as an accept refills it
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      data_p1 <= load_data;
      vld_p1  <= 1'b1;
      last_p1 <= load_last;
    end else if (vld_p1 && ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign data  = data_p1;
  assign valid = vld_p1;
  assign last  = last_p1;

endmodule

// File: rtl/scrambler_mux_sequencer.sv
// Sequencer for the 16-bit scrambler serial-in polynomial mux.
// Steps the mux phase select through consecutive phases (wrapping NUM_SEL-1
// -> 0) for frame_len words starting at start_sel, registers each mux word
// and presents it on a valid/ready stream with a last-word marker.
// Optional feature macro: SCRAMBLER_SEQ_ABORT_EN adds abort/aborted.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : single-cycle frame request (ignored while busy or len 0)
//   frame_len   : frame word count, sampled with start
//   start_sel   : first phase, sampled with start
//   pd_sel      : phase select driven to the mux
//   polydata_in : mux output word, combinational from pd_sel
//   out_data, out_valid, out_ready, out_last : output stream
//   busy        : frame in progress (RUN or DRAIN)
//   done        : one-cycle pulse after the last word is accepted
//   abort       : (macro only) cancel the frame in progress
//   aborted     : (macro only) one-cycle pulse after an abort
module scrambler_mux_sequencer #(
  parameter int SEL_W   = 5,
  parameter int NUM_SEL = 32,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [SEL_W-1:0]  start_sel,
  output logic [SEL_W-1:0]  pd_sel,
  input  logic [DATA_W-1:0] polydata_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef SCRAMBLER_SEQ_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  import scrambler_pkg::*;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             start_ok;
  logic             capture;
  logic             accept_last;
  logic             abort_act;
  logic             last_word;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    if (sel == SEL_W'(NUM_SEL - 1))
      return '0;
    else
      return sel + SEL_W'(1);
  endfunction

`ifdef SCRAMBLER_SEQ_ABORT_EN
  assign abort_act = abort && (state != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign start_ok    = (state == IDLE) && start && (frame_len != '0);
  assign capture     = (state == RUN) && (!out_valid || out_ready) && !abort_act;
  assign accept_last = (state == DRAIN) && out_valid && out_ready;
  assign last_word   = (remaining == LEN_W'(1));
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (capture && last_word) state_nxt = DRAIN;
      DRAIN:   if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_act)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Stage p0: select and length counters; pd_sel only moves on start or capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pd_sel    <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= accept_last && !abort_act;
      if (start_ok) begin
        pd_sel    <= start_sel;
        remaining <= frame_len;
      end else if (capture) begin
        pd_sel <= next_sel(pd_sel);
        if (remaining != '0)
          remaining <= remaining - LEN_W'(1);
      end
    end
  end

`ifdef SCRAMBLER_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst)
      aborted <= 1'b0;
    else
      aborted <= abort_act;
  end
`endif

  scrambler_seq_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_act),
    .load      (capture),
    .load_data (polydata_in),
    .load_last (last_word),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .last      (out_last)
  );

endmodule

// File: tb/tb_scrambler_mux_sequencer.sv
module tb_scrambler_mux_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  frame_len;
  logic [4:0]  start_sel;
  logic [4:0]  pd_sel;
  logic [15:0] polydata_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef SCRAMBLER_SEQ_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int checks    = 0;
  int failures  = 0;
  int acc_cnt   = 0;
  int done_cnt  = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  scrambler_mux_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .start_sel   (start_sel),
    .pd_sel      (pd_sel),
    .polydata_in (polydata_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef SCRAMBLER_SEQ_ABORT_EN
    ,
    .abort       (abort),
    .aborted     (aborted)
`endif
  );

  // Mux model: phase s yields 0xC000 | (s<<8) | s, e.g. phase 3 -> 16'hC303.
  function automatic logic [15:0] mux_word(input logic [4:0] s);
    return 16'hC000 | {3'b000, s, 3'b000, s};
  endfunction

  always_comb polydata_in = mux_word(pd_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("word_data", {16'd0, out_data}, {16'd0, e[16:1]});
          chk("word_last", {31'd0, out_last}, {31'd0, e[0]});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_words(input int len, input logic [4:0] sel, input int n_push);
    for (int i = 0; i < n_push; i++) begin
      logic [4:0] s;
      s = sel + 5'(i);
      exp_q.push_back({mux_word(s), (i == len - 1)});
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pd_sel"},    {27'd0, pd_sel},    32'd0);
    chk({tag, "_out_data"},  {16'd0, out_data},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  // Entered and left at posedge+1. Stall drops out_ready for stall_n cycles
  // after edge N+stall_at; extra_at pulses an ignored start while busy.
  task automatic run_frame(input int len, input logic [4:0] sel, input int stall_at,
                           input int stall_n, input int extra_at, input int exp_lat);
    int n;
    int acc0;
    logic [15:0] hold_d;
    logic [4:0]  hold_s;
    hold_d = '0;
    hold_s = '0;
    push_words(len, sel, len);
    frame_len = 8'(len);
    start_sel = sel;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy",   {31'd0, busy},   32'd1);
    chk("start_pd_sel", {27'd0, pd_sel}, {27'd0, sel});
    acc0 = acc_cnt;
    n = 0;
    while (n < 300) begin
      if (n > stall_at && n <= stall_at + stall_n) begin
        chk("stall_data",   {16'd0, out_data}, {16'd0, hold_d});
        chk("stall_pd_sel", {27'd0, pd_sel},   {27'd0, hold_s});
      end
      if (n == stall_at) begin
        out_ready = 1'b0;
        hold_d = out_data;
        hold_s = pd_sel;
      end
      if (n == stall_at + stall_n) out_ready = 1'b1;
      if (n == extra_at) begin
        start     = 1'b1;
        frame_len = 8'd2;
        start_sel = 5'd20;
      end
      if (n == extra_at + 1) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got none expected done within 300 cycles");
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_latency",   n,                          exp_lat);
    chk("done_busy_low",  {31'd0, busy},              32'd0);
    chk("words_accepted", acc_cnt - acc0,             len);
    chk("queue_empty",    exp_q.size(),               32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done},              32'd0);
    chk("idle_pd_hold",   {27'd0, pd_sel},            {27'd0, 5'(sel + 5'(len))});
  endtask

  initial begin
    int d0;
    logic bad;
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    start_sel = '0;
    out_ready = 1'b1;
`ifdef SCRAMBLER_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, phases 3..6, last with phase 6, done at N+5.
    run_frame(4, 5'd3, -1, 0, -1, 5);
    // Wrap: phases 30, 31, 0, 1.
    run_frame(4, 5'd30, -1, 0, -1, 5);
    // Same frame with out_ready low for three cycles.
    run_frame(4, 5'd30, 1, 3, -1, 8);

    // Zero-length start is ignored.
    frame_len = 8'd0;
    start_sel = 5'd9;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_len_busy", {31'd0, busy}, 32'd0);
    bad = 1'b0;
    repeat (5) begin
      if (out_valid || busy) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("zero_len_quiet", {31'd0, bad}, 32'd0);

    // Start while busy is ignored; first frame completes intact.
    run_frame(4, 5'd10, -1, 0, 2, 5);

    // Reset on the 2nd word of an 8-word frame; only word 1 is accepted.
    push_words(8, 5'd5, 1);
    frame_len = 8'd8;
    start_sel = 5'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_w2_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_w2_data",  {16'd0, out_data},  {16'd0, 16'hC606});
    d0 = done_cnt;
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    chk("midrst_queue", exp_q.size(), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_frame(3, 5'd0, -1, 0, -1, 4);

`ifdef SCRAMBLER_SEQ_ABORT_EN
    // Abort while the 3rd word is presented.
    push_words(6, 5'd8, 2);
    frame_len = 8'd6;
    start_sel = 5'd8;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_w3_data", {16'd0, out_data}, {16'd0, 16'hCA0A});
    d0 = done_cnt;
    abort     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy",    {31'd0, busy},      32'd0);
    chk("abort_valid",   {31'd0, out_valid}, 32'd0);
    chk("abort_last",    {31'd0, out_last},  32'd0);
    chk("abort_pulse",   {31'd0, aborted},   32'd1);
    chk("abort_queue",   exp_q.size(),       32'd0);
    @(posedge clk); #1;
    chk("abort_pulse_end", {31'd0, aborted}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
